// File: rtl/rv_muldiv_unit_if.sv
// Handshake/bus bundle between the EX stage (master) and the multiply/divide unit (slave).
interface rv_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             START;
  logic [2:0]       FUNCT3;
  logic [XLEN-1:0]  OP_A;
  logic [XLEN-1:0]  OP_B;
  logic [TAG_W-1:0] TAG_IN;
  logic             FLUSH;
  logic             BUSY;
  logic             DONE;
  logic [XLEN-1:0]  RESULT;
  logic [TAG_W-1:0] TAG_OUT;

  modport master (
    output START, FUNCT3, OP_A, OP_B, TAG_IN, FLUSH,
    input  BUSY, DONE, RESULT, TAG_OUT
  );

  modport slave (
    input  START, FUNCT3, OP_A, OP_B, TAG_IN, FLUSH,
    output BUSY, DONE, RESULT, TAG_OUT
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, on a shared magnitude datapath with sign fix-up at the end.
module rv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  rv_muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [XLEN-1:0]    result_reg, result_next;
  logic [TAG_W-1:0]   tag_out_reg, tag_out_next;
  logic [TAG_W-1:0]   tag_pend_reg, tag_pend_next;
  logic [2:0]         funct3_reg, funct3_next;
  logic               sign_reg, sign_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  // hi: product high half / partial remainder; lo: multiplier / dividend->quotient
  logic [XLEN:0]      hi_reg, hi_next;
  logic [XLEN-1:0]    lo_reg, lo_next;
  logic [XLEN-1:0]    b_reg, b_next;

  logic               signed_a, signed_b, s_a, s_b, is_div;
  logic               div_zero, div_ovf, accept;
  logic [XLEN-1:0]    mag_a, mag_b, fast_res;
  logic [XLEN:0]      mul_sum, div_r, div_trial;
  logic [2*XLEN-1:0]  prod, prod_fix;
  logic [XLEN-1:0]    quot_fix, rem_fix, fix_res;

  always_comb begin
    is_div   = bus.FUNCT3[2];
    signed_a = (bus.FUNCT3 == 3'b001) || (bus.FUNCT3 == 3'b010) ||
               (bus.FUNCT3 == 3'b100) || (bus.FUNCT3 == 3'b110);
    signed_b = (bus.FUNCT3 == 3'b001) || (bus.FUNCT3 == 3'b100) || (bus.FUNCT3 == 3'b110);
    s_a      = signed_a && bus.OP_A[XLEN-1];
    s_b      = signed_b && bus.OP_B[XLEN-1];
    mag_a    = s_a ? -bus.OP_A : bus.OP_A;
    mag_b    = s_b ? -bus.OP_B : bus.OP_B;
    div_zero = is_div && (bus.OP_B == '0);
    div_ovf  = is_div && !bus.FUNCT3[0] && (bus.OP_A == MIN_NEG) && (bus.OP_B == '1);
    if (div_zero)
      fast_res = bus.FUNCT3[1] ? bus.OP_A : '1;
    else
      fast_res = bus.FUNCT3[1] ? '0 : bus.OP_A;
    accept   = bus.START && (state_reg == IDLE) && !bus.FLUSH;
  end

  always_comb begin
    mul_sum   = hi_reg + (lo_reg[0] ? {1'b0, b_reg} : '0);
    div_r     = {hi_reg[XLEN-1:0], lo_reg[XLEN-1]};
    div_trial = div_r - {1'b0, b_reg};
    prod      = {hi_reg[XLEN-1:0], lo_reg};
    // Sign is applied to the full double-width product so the high half borrows correctly.
    prod_fix  = sign_reg ? -prod : prod;
    quot_fix  = sign_reg ? -lo_reg : lo_reg;
    rem_fix   = sign_reg ? -hi_reg[XLEN-1:0] : hi_reg[XLEN-1:0];
    case (funct3_reg)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    done_next     = 1'b0;
    result_next   = result_reg;
    tag_out_next  = tag_out_reg;
    tag_pend_next = tag_pend_reg;
    funct3_next   = funct3_reg;
    sign_next     = sign_reg;
    cnt_next      = cnt_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    b_next        = b_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          funct3_next   = bus.FUNCT3;
          tag_pend_next = bus.TAG_IN;
          if (div_zero || div_ovf) begin
            result_next  = fast_res;
            tag_out_next = bus.TAG_IN;
            done_next    = 1'b1;
          end else begin
            state_next = CALC;
            sign_next  = (is_div && bus.FUNCT3[1]) ? s_a : (s_a ^ s_b);
            cnt_next   = CNT_W'(XLEN - 1);
            hi_next    = '0;
            lo_next    = mag_a;
            b_next     = mag_b;
          end
        end
      end
      CALC: begin
        if (bus.FLUSH) begin
          state_next = IDLE;
        end else begin
          if (funct3_reg[2]) begin
            if (!div_trial[XLEN]) begin
              hi_next = div_trial;
              lo_next = {lo_reg[XLEN-2:0], 1'b1};
            end else begin
              hi_next = div_r;
              lo_next = {lo_reg[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_next = {1'b0, mul_sum[XLEN:1]};
            lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
          end
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == '0)
            state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        if (!bus.FLUSH) begin
          result_next  = fix_res;
          tag_out_next = tag_pend_reg;
          done_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      tag_out_reg  <= '0;
      tag_pend_reg <= '0;
      funct3_reg   <= '0;
      sign_reg     <= 1'b0;
      cnt_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      b_reg        <= '0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      tag_out_reg  <= tag_out_next;
      tag_pend_reg <= tag_pend_next;
      funct3_reg   <= funct3_next;
      sign_reg     <= sign_next;
      cnt_reg      <= cnt_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      b_reg        <= b_next;
    end
  end

  assign bus.BUSY    = busy_reg;
  assign bus.DONE    = done_reg;
  assign bus.RESULT  = result_reg;
  assign bus.TAG_OUT = tag_out_reg;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit (XLEN=32): M-extension results, latency, fast paths,
// back-to-back issue, busy rejection, flush and asynchronous reset.
module tb_rv_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rv_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus ();

  rv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one edge, then scramble the operand inputs.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    bus.START  = 1'b1;
    bus.FUNCT3 = f;
    bus.OP_A   = a;
    bus.OP_B   = b;
    bus.TAG_IN = t;
    step();
    bus.START  = 1'b0;
    bus.OP_A   = $urandom;
    bus.OP_B   = $urandom;
    bus.TAG_IN = 5'($urandom);
    bus.FUNCT3 = 3'($urandom);
  endtask

  // Issue an op and wait for DONE; lat counts edges after the accepting edge.
  // poke>0 pulses a competing START that many cycles in, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp,
                        input int lat, input int poke);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    issue(f, a, b, t);
    while (!bus.DONE && n < 200) begin
      if (bus.BUSY) busy_cnt++;
      if (poke > 0 && n == poke) begin
        bus.START  = 1'b1;
        bus.FUNCT3 = 3'b000;
        bus.OP_A   = 32'd3;
        bus.OP_B   = 32'd3;
        bus.TAG_IN = 5'd1;
      end
      step();
      bus.START = 1'b0;
      n++;
    end
    chk({tag, ".lat"}, 64'(n), 64'(lat));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(lat));
    chk({tag, ".done"}, 64'(bus.DONE), 64'd1);
    chk({tag, ".busy_at_done"}, 64'(bus.BUSY), 64'd0);
    chk({tag, ".result"}, 64'(bus.RESULT), 64'(exp));
    chk({tag, ".tag"}, 64'(bus.TAG_OUT), 64'(t));
  endtask

  initial begin
    logic saw_done;
    bus.START  = 1'b0;
    bus.FLUSH  = 1'b0;
    bus.FUNCT3 = 3'b000;
    bus.OP_A   = '0;
    bus.OP_B   = '0;
    bus.TAG_IN = '0;

    step();
    chk("rst.busy", 64'(bus.BUSY), 64'd0);
    chk("rst.done", 64'(bus.DONE), 64'd0);
    chk("rst.result", 64'(bus.RESULT), 64'd0);
    chk("rst.tag", 64'(bus.TAG_OUT), 64'd0);
    rst = 1'b0;
    step();

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 33, 0);
    step();
    chk("mul.done_drop", 64'(bus.DONE), 64'd0);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 33, 0);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 33, 0);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, 0);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 0);
    run_op("remu", 3'b111, 32'd7, 32'd2, 5'd7, 32'd1, 33, 0);
    // Issued in the DONE cycle of REMU, with a START pulsed while busy.
    run_op("divu_b2b", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 33, 10);
    step();
    chk("divu_b2b.done_drop", 64'(bus.DONE), 64'd0);
    chk("divu_b2b.result_hold", 64'(bus.RESULT), 64'd14);
    chk("divu_b2b.idle_busy", 64'(bus.BUSY), 64'd0);

    run_op("divu_zero", 3'b101, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 0, 0);
    run_op("remu_zero", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 0, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 0, 0);
    step();
    chk("fast.done_drop", 64'(bus.DONE), 64'd0);

    // START together with FLUSH in IDLE is dropped.
    bus.START  = 1'b1;
    bus.FLUSH  = 1'b1;
    bus.FUNCT3 = 3'b101;
    bus.OP_A   = 32'd5;
    bus.OP_B   = 32'd0;
    step();
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    chk("flush_start.busy", 64'(bus.BUSY), 64'd0);
    chk("flush_start.done", 64'(bus.DONE), 64'd0);
    chk("flush_start.result", 64'(bus.RESULT), 64'd0);

    // Flush mid-CALC: no DONE, outputs keep the REM overflow result and tag.
    issue(3'b000, 32'd5, 32'd5, 5'd20);
    for (int i = 0; i < 9; i++) step();
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    chk("flush.busy", 64'(bus.BUSY), 64'd0);
    chk("flush.done", 64'(bus.DONE), 64'd0);
    chk("flush.result", 64'(bus.RESULT), 64'd0);
    chk("flush.tag", 64'(bus.TAG_OUT), 64'd16);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      saw_done = saw_done | bus.DONE;
    end
    chk("flush.no_done", 64'(saw_done), 64'd0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33, 0);

    // Asynchronous reset between edges while in CALC.
    issue(3'b101, 32'd100, 32'd7, 5'd22);
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst.busy", 64'(bus.BUSY), 64'd0);
    chk("arst.done", 64'(bus.DONE), 64'd0);
    chk("arst.result", 64'(bus.RESULT), 64'd0);
    chk("arst.tag", 64'(bus.TAG_OUT), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst.stay_idle", 64'(bus.BUSY), 64'd0);
    run_op("mulhu_after_rst", 3'b011, 32'h0001_0000, 32'h0003_0000, 5'd23, 32'd3, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
